width_report_sched: RTL and testbench



---
 rtl/width_report_pkg.sv | 28 ++
 rtl/width_report_sched_if.sv | 29 ++
 rtl/width_report_sched_rr_pick.sv | 33 +++
 rtl/width_report_sched.sv | 134 +++++++++++++
 tb/tb_width_report_sched.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/width_report_pkg.sv
// Shared types for the width report scheduler: beat kinds, FSM states, record length.
// REPORT_SEQ_EN adds a fourth (sequence counter) beat to every record.
package width_report_pkg;

  typedef enum logic [1:0] {
    KIND_T     = 2'd0,
    KIND_WIDTH = 2'd1,
    KIND_OTHER = 2'd2,
    KIND_SEQ   = 2'd3
  } kind_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

`ifdef REPORT_SEQ_EN
  localparam kind_e LAST_BEAT = KIND_SEQ;
`else
  localparam kind_e LAST_BEAT = KIND_OTHER;
`endif

  // Requester index width; a single requester still gets a 1-bit id.
  function automatic int id_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/width_report_sched_if.sv
// Request and report-stream bundle; master = scheduler side, slave = requesters plus sink.
interface width_report_sched_if
  import width_report_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int WIDTH_W = 8
);
  localparam int ID_W = id_bits(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*WIDTH_W-1:0] req_width;
  logic [N_REQ-1:0]         req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [ID_W-1:0]          out_id;
  logic [1:0]               out_kind;
  logic [WIDTH_W:0]         out_value;
  logic                     busy;

  modport master (
    input  req_valid, req_width, out_ready,
    output req_ready, out_valid, out_id, out_kind, out_value, busy
  );

  modport slave (
    output req_valid, req_width, out_ready,
    input  req_ready, out_valid, out_id, out_kind, out_value, busy
  );
endinterface

// File: rtl/width_report_sched_rr_pick.sv
// Combinational round-robin picker: one-hot grant on the first valid bit after last, wrapping.
// Zero latency; grant is all-zero when nothing is valid.
module rr_pick
  import width_report_pkg::*;
#(
  parameter int N    = 3,
  parameter int ID_W = id_bits(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = last;
    for (int k = 0; k < N; k++) begin
      cand = (cand == ID_W'(N - 1)) ? '0 : cand + 1'b1;
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/width_report_sched.sv
// Round-robin shares one report stream among N_REQ requesters; grant to first beat 1 cycle, 3 beats per record (4 with REPORT_SEQ_EN).
// Beats hold stable while out_ready is low; requesters wait on req_ready, one idle cycle between records.
module width_report_sched
  import width_report_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int WIDTH_W     = 8,
  parameter int DEFAULT_T   = 1,
  parameter int WIDTH_CONST = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  width_report_sched_if.master bus
);

  localparam int ID_W  = id_bits(N_REQ);
  localparam int VAL_W = WIDTH_W + 1;

  state_e             state_q, state_d;
  kind_e              beat_q, beat_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [WIDTH_W-1:0] t_q, t_d;

  logic [N_REQ-1:0]   pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic [WIDTH_W-1:0] pick_width;

  logic [N_REQ-1:0]   req_ready_c;
  logic               out_valid_c;
  logic               busy_c;
  logic [VAL_W-1:0]   value_c;

  rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .valid (bus.req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_width = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) pick_width = bus.req_width[i*WIDTH_W +: WIDTH_W];
    end
  end

`ifdef REPORT_SEQ_EN
  // Counts records whose final beat has been accepted.
  logic [VAL_W-1:0] seq_q;
  logic             rec_done;

  assign rec_done = out_valid_c & bus.out_ready & (beat_q == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst)           seq_q <= '0;
    else if (rec_done) seq_q <= seq_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= KIND_T;
      id_q    <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      id_q    <= id_d;
      last_q  <= last_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    id_d        = id_q;
    last_d      = last_q;
    t_d         = t_q;
    req_ready_c = '0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_c = pick_grant;
        if (|bus.req_valid) begin
          id_d    = pick_idx;
          last_d  = pick_idx;
          t_d     = (pick_width == '0) ? WIDTH_W'(DEFAULT_T) : pick_width;
          beat_d  = KIND_T;
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = KIND_T;
            state_d = IDLE;
          end else begin
            beat_d = kind_e'(beat_q + 2'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload derives only from registered state, so it cannot move during a stall.
  always_comb begin
    value_c = '0;
    case (beat_q)
      KIND_T:     value_c = VAL_W'(t_q);
      KIND_WIDTH: value_c = VAL_W'(WIDTH_CONST);
      KIND_OTHER: value_c = {t_q, 1'b0};
`ifdef REPORT_SEQ_EN
      KIND_SEQ:   value_c = seq_q;
`endif
      default:    value_c = '0;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_id    = id_q;
  assign bus.out_kind  = beat_q;
  assign bus.out_value = value_c;

endmodule

// File: tb/tb_width_report_sched.sv
// Scoreboard bench for width_report_sched: a reference round-robin model predicts grants and beats.
module tb_width_report_sched;

  localparam int N     = 3;
  localparam int W     = 8;
  localparam int DEF_T = 1;
  localparam int WCON  = 32;
  localparam int VMASK = (1 << (W + 1)) - 1;
`ifdef REPORT_SEQ_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  width_report_sched_if #(.N_REQ(N), .WIDTH_W(W)) bus ();

  width_report_sched #(
    .N_REQ(N), .WIDTH_W(W), .DEFAULT_T(DEF_T), .WIDTH_CONST(WCON)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int id;
    int kind;
    int val;
  } exp_t;

  exp_t q[$];
  int   order[$];
  int   seqv[$];
  int   total = 0;
  int   bad = 0;
  bit   m_busy = 1'b0;
  int   last_m = N - 1;
  int   seq_m = 0;
  int   busy_cnt = 0;
  int   c_m;
  bit   found_m;
  int   t_m;
  exp_t b_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_busy = 1'b0;
      last_m = N - 1;
      seq_m  = 0;
    end else if (!m_busy) begin
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_busy", bus.busy, 0);
      found_m = 1'b0;
      c_m     = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found_m && bus.req_valid[(last_m + k) % N]) begin
          found_m = 1'b1;
          c_m     = (last_m + k) % N;
        end
      end
      if (found_m) begin
        chk("grant", bus.req_ready, 32'(1) << c_m);
        t_m = int'(bus.req_width[c_m*W +: W]);
        if (t_m == 0) t_m = DEF_T;
        q.push_back('{c_m, 0, t_m});
        q.push_back('{c_m, 1, WCON & VMASK});
        q.push_back('{c_m, 2, 2 * t_m});
`ifdef REPORT_SEQ_EN
        q.push_back('{c_m, 3, seq_m & VMASK});
`endif
        order.push_back(c_m);
        last_m = c_m;
        m_busy = 1'b1;
      end else begin
        chk("no_grant", bus.req_ready, 0);
      end
    end else begin
      if (bus.busy) busy_cnt++;
      chk("emit_valid", bus.out_valid, 1);
      chk("emit_busy", bus.busy, 1);
      chk("emit_ready", bus.req_ready, 0);
      chk("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        chk("beat_id", bus.out_id, q[0].id);
        chk("beat_kind", bus.out_kind, q[0].kind);
        chk("beat_value", bus.out_value, q[0].val);
        if (bus.out_valid && bus.out_ready) begin
          b_m = q.pop_front();
          if (b_m.kind == 3) seqv.push_back(int'(bus.out_value));
          if (b_m.kind == NB - 1) begin
            m_busy = 1'b0;
            seq_m++;
          end
        end
      end
    end
  end

  // One cycle: drive out_ready, drop requests that were granted this cycle.
  task automatic step(input bit rdy);
    logic [N-1:0] g;
    bus.out_ready = rdy;
    @(negedge clk);
    g = bus.req_ready & bus.req_valid;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~g;
  endtask

  task automatic post(input int i, input int w);
    bus.req_valid[i]         = 1'b1;
    bus.req_width[i*W +: W]  = W'(w);
  endtask

  task automatic drain(input string tag, input logic [3:0] pat);
    int n = 0;
    while ((bus.req_valid != 0 || m_busy || bus.out_valid) && n < 200) begin
      step(pat[n[1:0]]);
      n++;
    end
    chk(tag, n < 200, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit reached;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_width = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_out_kind", bus.out_kind, 0);
    chk("rst_out_value", bus.out_value, 0);
    @(posedge clk);
    #1;

    // Single requester, sink always ready.
    busy_cnt = 0;
    order.delete();
    post(0, 8);
    drain("t1_drain", 4'b1111);
    chk("t1_busy_cycles", busy_cnt, NB);
    chk("t1_records", order.size(), 1);

    // Three simultaneous requesters from reset priority.
    do_reset();
    order.delete();
    post(0, 8);
    post(1, 16);
    post(2, 32);
    drain("t2_drain", 4'b1111);
    chk("t2_records", order.size(), 3);
    for (int i = 0; i < order.size(); i++) chk("t2_order", order[i], i);

    // Width 0 substituted by the default.
    post(1, 0);
    drain("t3_drain", 4'b1111);

    // Full-scale width with a stalling sink.
    post(2, 255);
    drain("t4_drain", 4'b1001);

    // A losing requester withdraws before it is served.
    order.delete();
    post(0, 3);
    post(1, 4);
    step(1'b1);
    bus.req_valid[1] = 1'b0;
    drain("t5_drain", 4'b1111);
    chk("t5_records", order.size(), 1);

    // Reset in the middle of a record.
    post(0, 5);
    reached = 1'b0;
    for (int n = 0; n < 20 && !reached; n++) begin
      step(1'b1);
      if (bus.out_valid && bus.out_kind == 2'd1) reached = 1'b1;
    end
    chk("t6_mid_reached", reached, 1);
    do_reset();
    @(negedge clk);
    chk("t6_abort_valid", bus.out_valid, 0);
    chk("t6_abort_kind", bus.out_kind, 0);
    @(posedge clk);
    #1;
    order.delete();
    post(2, 7);
    drain("t6_drain", 4'b1111);
    chk("t6_records", order.size(), 1);
    if (order.size() > 0) chk("t6_id", order[0], 2);

`ifdef REPORT_SEQ_EN
    do_reset();
    seqv.delete();
    for (int r = 0; r < 3; r++) begin
      post(0, 5);
      drain("t7_drain", 4'b1111);
    end
    chk("t7_seq_len", seqv.size(), 3);
    for (int i = 0; i < seqv.size(); i++) chk("t7_seq_val", seqv[i], i);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
